generic_fifo_rd_stream: RTL

GENERIC_FIFO_RD_STREAM -- requirements
Module: generic_fifo_rd_stream

---
 rtl/generic_fifo_rd_stream_pkg.sv | 7 +
 rtl/generic_fifo_rd_stream_if.sv | 20 ++
 rtl/generic_fifo_rd_stream_skid2.sv | 29 ++
 rtl/generic_fifo_rd_stream.sv | 61 ++++++
 4 files changed

// File: rtl/generic_fifo_rd_stream_pkg.sv
// generic_fifo_rd_stream_pkg: shared state encoding and buffer/latency constants
package generic_fifo_rd_stream_pkg;
    typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;
    localparam int BUF_DEPTH = 2;
    localparam int RD_LAT = 1;
    localparam int OCC_W = $clog2(BUF_DEPTH + 1);
endpackage

// File: rtl/generic_fifo_rd_stream_if.sv
// generic_fifo_rd_stream_if: FIFO read port plus valid/ready output stream
// master: the reader block (drives fifo_rd_op, out_valid, out_data)
// slave: the FIFO/consumer side (drives fifo_empty, fifo_rd_data, fifo_rd_empty_err, out_ready)
interface generic_fifo_rd_stream_if #(parameter int DAT_WIDTH = 32) ();
    logic fifo_empty;
    logic [DAT_WIDTH-1:0] fifo_rd_data;
    logic fifo_rd_empty_err;
    logic fifo_rd_op;
    logic out_valid;
    logic [DAT_WIDTH-1:0] out_data;
    logic out_ready;
    modport master (
        input fifo_empty, fifo_rd_data, fifo_rd_empty_err, out_ready,
        output fifo_rd_op, out_valid, out_data
    );
    modport slave (
        output fifo_empty, fifo_rd_data, fifo_rd_empty_err, out_ready,
        input fifo_rd_op, out_valid, out_data
    );
endinterface

// File: rtl/generic_fifo_rd_stream_skid2.sv
// fifo_rd_skid2: two-entry in-order word buffer
// ports: push/din write, pop advances head, clr empties, dout is the head word, occ 0..2
module fifo_rd_skid2 import generic_fifo_rd_stream_pkg::*; #(
    parameter int DAT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clr,
    input  logic                 push,
    input  logic                 pop,
    input  logic [DAT_WIDTH-1:0] din,
    output logic [DAT_WIDTH-1:0] dout,
    output logic [OCC_W-1:0]     occ
);
    logic [DAT_WIDTH-1:0] tail;
    // with a pop the new word lands at the head only if it would otherwise be alone
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            dout <= '0;
            tail <= '0;
            occ  <= '0;
        end else if (clr) begin
            occ <= '0;
        end else begin
            dout <= pop ? (push && occ == OCC_W'(1) ? din : tail) : (push && occ == '0 ? din : dout);
            tail <= push && occ == (pop ? OCC_W'(2) : OCC_W'(1)) ? din : tail;
            occ  <= occ + OCC_W'(push) - OCC_W'(pop);
        end
endmodule

// File: rtl/generic_fifo_rd_stream.sv
// generic_fifo_rd_stream: turns a FIFO read port into a valid/ready word stream
// ports: en starts reads, flush discards buffered/in-flight words, bus carries FIFO and stream
// signals, busy/rd_cnt report activity and delivered words, err is a sticky empty-read error
module generic_fifo_rd_stream import generic_fifo_rd_stream_pkg::*; #(
    parameter int DAT_WIDTH = 32,
    parameter int CNT_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic                  flush,
    input  logic                  err_clr,
    generic_fifo_rd_stream_if.master bus,
    output logic                  busy,
    output logic [CNT_WIDTH-1:0]  rd_cnt,
    output logic                  err
);
    localparam logic [OCC_W:0] DEPTH = (OCC_W + 1)'(BUF_DEPTH);
    state_t state, state_nxt;
    logic [RD_LAT-1:0] rd_pipe;
    logic [OCC_W-1:0] occ;
    logic [OCC_W:0] outstanding;
    logic inflight, pop, push, credit;
    assign inflight = rd_pipe[RD_LAT-1];
    assign pop = bus.out_valid && bus.out_ready;
    // reads in flight already own a buffer slot
    assign outstanding = {1'b0, occ} + (OCC_W + 1)'(inflight);
    assign credit = outstanding < DEPTH || (outstanding == DEPTH && pop);
    assign bus.fifo_rd_op = state == RUN && !bus.fifo_empty && credit;
    // returning data is dropped while flushing
    assign push = inflight && !flush && state != FLUSH;
    assign bus.out_valid = occ != '0;
    assign busy = bus.out_valid || inflight || state == FLUSH;
    always_comb
        state_nxt = flush ? FLUSH :
                    state == IDLE && en ? RUN :
                    state == RUN && !en ? IDLE :
                    state == FLUSH && !inflight ? IDLE : state;
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            state   <= IDLE;
            rd_pipe <= '0;
            rd_cnt  <= '0;
            err     <= 1'b0;
        end else begin
            state   <= state_nxt;
            rd_pipe <= RD_LAT'({rd_pipe, bus.fifo_rd_op});
            rd_cnt  <= flush ? '0 : rd_cnt + CNT_WIDTH'(pop);
            err     <= bus.fifo_rd_empty_err || (err && !err_clr);
        end
    fifo_rd_skid2 #(.DAT_WIDTH(DAT_WIDTH)) u_skid (
        .clk  (clk),
        .reset(reset),
        .clr  (flush),
        .push (push),
        .pop  (pop),
        .din  (bus.fifo_rd_data),
        .dout (bus.out_data),
        .occ  (occ)
    );
endmodule
